// File: rtl/wb_madgwick_slave.sv
// Wishbone classic slave for the Madgwick filter window: operand staging,
// compute-core launch/abort sequencing, quaternion capture and interrupt.
module wb_madgwick_slave #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] Q_ONE          = 32'h4000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_n_i,
    input  logic [31:0]  wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    input  logic [3:0]   wb_sel_i,
    input  logic         wb_we_i,
    input  logic         wb_cyc_i,
    input  logic         wb_stb_i,
    input  logic [2:0]   wb_cti_i,
    input  logic [1:0]   wb_bte_i,
    output logic [31:0]  wb_dat_o,
    output logic         wb_ack_o,
    output logic         wb_err_o,
    output logic         wb_rty_o,
    output logic [351:0] core_operand_o,
    output logic         core_start_o,
    output logic         core_abort_o,
    input  logic         core_done_i,
    input  logic [127:0] core_q_i,
    output logic         irq_o
);
    localparam int unsigned DW   = 32;
    localparam int unsigned NOPS = 11;
    localparam int unsigned NQ   = 4;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   stg_q [NOPS];
    logic [DW-1:0]   stg_d [NOPS];
    logic [DW-1:0]   op_q  [NOPS];
    logic [DW-1:0]   op_d  [NOPS];
    logic [DW-1:0]   q_q   [NQ];
    logic [DW-1:0]   q_d   [NQ];
    logic [DW-1:0]   wdog_q, wdog_d, count_q, count_d, dat_q, dat_d, rdata_c;
    logic            ack_q, ack_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic            done_q, done_d, overrun_q, overrun_d, timeout_q, timeout_d;
    logic            start_q, start_d, abort_q, abort_d;
    logic            req_c, wr_c, ctrl_wr_c, stat_wr_c, go_c, srst_c;
    logic [4:0]      word_c;
    logic            unused_c;

    assign unused_c  = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:7], wb_adr_i[1:0]};
    assign req_c     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_c      = req_c & wb_we_i;
    assign word_c    = wb_adr_i[6:2];
    assign ctrl_wr_c = wr_c & (word_c == 5'd0) & wb_sel_i[0];
    assign stat_wr_c = wr_c & (word_c == 5'd1) & wb_sel_i[0];
    assign go_c      = ctrl_wr_c & wb_dat_i[0];
    assign srst_c    = ctrl_wr_c & wb_dat_i[2];

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign wb_err_o     = 1'b0;
    assign wb_rty_o     = 1'b0;
    assign core_start_o = start_q;
    assign core_abort_o = abort_q;
    assign irq_o        = irq_q;

    always_comb begin
        core_operand_o = '0;
        for (int i = 0; i < NOPS; i++) core_operand_o[i*DW +: DW] = op_q[i];
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [3:0]    sel);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Read mux, sampled on the request cycle.
    always_comb begin
        rdata_c = '0;
        if (word_c == 5'd0)
            rdata_c = {30'd0, irq_en_q, 1'b0};
        else if (word_c == 5'd1)
            rdata_c = {28'd0, timeout_q, overrun_q, done_q, state_q != S_IDLE};
        else if (word_c >= 5'd2 && word_c <= 5'd12)
            rdata_c = stg_q[4'(word_c - 5'd2)];
        else if (word_c >= 5'd16 && word_c <= 5'd19)
            rdata_c = q_q[word_c[1:0]];
        else if (word_c == 5'd20)
            rdata_c = count_q;
    end

    always_comb begin
        state_d   = state_q;
        stg_d     = stg_q;
        op_d      = op_q;
        q_d       = q_q;
        wdog_d    = wdog_q;
        count_d   = count_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        abort_d   = 1'b0;
        ack_d     = req_c;
        dat_d     = (req_c & ~wb_we_i) ? rdata_c : '0;
        irq_d     = (done_q | timeout_q) & irq_en_q;

        if (ctrl_wr_c) irq_en_d = wb_dat_i[1];
        if (wr_c && word_c >= 5'd2 && word_c <= 5'd12)
            stg_d[4'(word_c - 5'd2)] = merge(stg_q[4'(word_c - 5'd2)], wb_dat_i, wb_sel_i);

        // Clears are applied first so a same-cycle hardware set wins.
        if (stat_wr_c) begin
            if (wb_dat_i[1]) done_d    = 1'b0;
            if (wb_dat_i[2]) overrun_d = 1'b0;
            if (wb_dat_i[3]) timeout_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d = S_LAUNCH;
                    op_d    = stg_q;
                end
            end
            S_LAUNCH: begin
                if (go_c) overrun_d = 1'b1;
                state_d = S_RUN;
                wdog_d  = '0;
            end
            S_RUN: begin
                if (go_c) overrun_d = 1'b1;
                if (core_done_i) begin
                    for (int i = 0; i < NQ; i++) q_d[i] = core_q_i[i*DW +: DW];
                    done_d  = 1'b1;
                    count_d = count_q + DW'(1);
                    state_d = S_IDLE;
                end else if (wdog_q == DW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Soft reset overrides everything above, including a same-write START.
        if (srst_c) begin
            state_d   = S_IDLE;
            op_d      = op_q;
            abort_d   = (state_q != S_IDLE);
            q_d[0]    = Q_ONE;
            for (int i = 1; i < NQ; i++) q_d[i] = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            count_d   = '0;
        end

        start_d = (state_d == S_LAUNCH);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < NOPS; i++) begin
                stg_q[i] <= '0;
                op_q[i]  <= '0;
            end
            q_q[0]    <= Q_ONE;
            for (int i = 1; i < NQ; i++) q_q[i] <= '0;
            wdog_q    <= '0;
            count_q   <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stg_q     <= stg_d;
            op_q      <= op_d;
            q_q       <= q_d;
            wdog_q    <= wdog_d;
            count_q   <= count_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
        end
    end
endmodule
